// File: rtl/mac_tx_arbiter.sv
// Round-robin arbiter that merges NUM_REQ byte-stream frame sources onto one
// MAC TX payload interface. Frames are forwarded whole; any frame longer than
// MAX_BEATS is cut at MAX_BEATS with a forced end-of-frame, and its tail is
// swallowed before the arbiter re-arbitrates.
module mac_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BEATS = 1500,
  localparam int GW       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   s_valid,
  input  logic [NUM_REQ*8-1:0] s_data,
  input  logic [NUM_REQ-1:0]   s_eof,
  output logic [NUM_REQ-1:0]   s_ready,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [7:0]           m_data,
  output logic                 m_eof,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 oversize,
  output logic [15:0]          oversize_cnt
);

  typedef enum logic [1:0] {IDLE, FORWARD, DRAIN} state_t;

  localparam logic [10:0] LAST_BEAT = 11'(MAX_BEATS - 1);

  state_t               state_q;
  logic [GW-1:0]        grant_q;
  logic [10:0]          beat_q;
  logic                 oversize_q;
  logic [15:0]          ovcnt_q;
  logic                 busy_q;

  logic [GW-1:0]        start_idx;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [GW-1:0]        grant_d;
  logic [7:0]           byte_arr [NUM_REQ];
  logic                 g_valid;
  logic                 g_eof;
  logic [7:0]           g_data;
  logic                 g_accept;
  logic                 force_eof;

  // Round-robin search starts one past the last grant, wrapping to 0.
  assign start_idx = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
  assign dbl_valid = {s_valid, s_valid};
  assign rot_valid = NUM_REQ'(dbl_valid >> start_idx);

  // Pick the first valid requester in rotated order and map it back to an index.
  always_comb begin
    logic found;
    int   sum;
    grant_d = grant_q;
    found   = 1'b0;
    sum     = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && rot_valid[j]) begin
        found   = 1'b1;
        sum     = int'(start_idx) + j;
        grant_d = (sum >= NUM_REQ) ? GW'(sum - NUM_REQ) : GW'(sum);
      end
    end
  end

  // Per-requester byte lanes and ready steering.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign byte_arr[gi] = s_data[8*gi +: 8];
      assign s_ready[gi]  = !reset && (grant_q == GW'(gi)) &&
                            (((state_q == FORWARD) && m_ready) || (state_q == DRAIN));
    end
  endgenerate

  assign g_valid   = s_valid[grant_q];
  assign g_eof     = s_eof[grant_q];
  assign g_data    = byte_arr[grant_q];
  assign g_accept  = g_valid && m_ready;
  // The MAX_BEATS-th byte of a frame that has not ended becomes its last byte.
  assign force_eof = (beat_q == LAST_BEAT) && !g_eof;

  // Outputs are forced quiet while reset is asserted so a cut frame never shows an eof.
  assign m_valid      = !reset && (state_q == FORWARD) && g_valid;
  assign m_data       = g_data;
  assign m_eof        = m_valid && (g_eof || force_eof);
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  assign oversize     = oversize_q;
  assign oversize_cnt = ovcnt_q;

  // Frame FSM: arbitrate in IDLE, pass bytes in FORWARD, discard the tail in DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= GW'(NUM_REQ - 1);
      beat_q     <= '0;
      oversize_q <= 1'b0;
      ovcnt_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      oversize_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|s_valid) begin
            grant_q <= grant_d;
            beat_q  <= '0;
            state_q <= FORWARD;
            busy_q  <= 1'b1;
          end
        end
        FORWARD: begin
          if (g_accept) begin
            beat_q <= beat_q + 11'd1;
            if (g_eof) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (beat_q == LAST_BEAT) begin
              state_q    <= DRAIN;
              oversize_q <= 1'b1;
              if (ovcnt_q != 16'hFFFF) begin
                ovcnt_q <= ovcnt_q + 16'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (g_valid && g_eof) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: a default-size instance and one with
// MAX_BEATS=8 share the same byte sources; per-requester sources emit
// byte = req*16 + position and a monitor logs every accepted m_* beat.
module tb_mac_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  s_valid = '0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_eof = '0;
  logic        m_ready = 1'b1;

  logic [3:0]  s_ready_a, s_ready_b;
  logic        m_valid_a, m_valid_b, m_eof_a, m_eof_b;
  logic [7:0]  m_data_a, m_data_b;
  logic [1:0]  grant_a, grant_b;
  logic        busy_a, busy_b, ovs_a, ovs_b;
  logic [15:0] ovcnt_a, ovcnt_b;

  mac_tx_arbiter #(.NUM_REQ(4), .MAX_BEATS(1500)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_eof(s_eof),
    .s_ready(s_ready_a), .m_ready(m_ready), .m_valid(m_valid_a), .m_data(m_data_a),
    .m_eof(m_eof_a), .grant_id(grant_a), .busy(busy_a), .oversize(ovs_a),
    .oversize_cnt(ovcnt_a));

  mac_tx_arbiter #(.NUM_REQ(4), .MAX_BEATS(8)) dut8 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_eof(s_eof),
    .s_ready(s_ready_b), .m_ready(m_ready), .m_valid(m_valid_b), .m_data(m_data_b),
    .m_eof(m_eof_b), .grant_id(grant_b), .busy(busy_b), .oversize(ovs_b),
    .oversize_cnt(ovcnt_b));

  always #4 clk = ~clk;

  // Selected instance whose handshakes drive the sources and the log.
  bit         sel8 = 1'b0;
  logic [3:0] srdy;
  logic       mv, me, ovs;
  logic [7:0] md;
  logic [1:0] gid;
  assign srdy = sel8 ? s_ready_b : s_ready_a;
  assign mv   = sel8 ? m_valid_b : m_valid_a;
  assign me   = sel8 ? m_eof_b   : m_eof_a;
  assign md   = sel8 ? m_data_b  : m_data_a;
  assign gid  = sel8 ? grant_b   : grant_a;
  assign ovs  = sel8 ? ovs_b     : ovs_a;

  int  len [4];
  int  frames [4];
  int  pos [4];
  bit  hold [4];
  bit  acc [4];
  bit  rmode = 1'b0;

  logic [7:0] q_data [$];
  bit         q_eof [$];
  int         q_gid [$];
  int         q_cyc [$];
  int         ov_pulses = 0;
  int         ov_cyc = 0;
  int         cyc = 0;

  int checks = 0;
  int errors = 0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      len[i] = 1; frames[i] = 0; pos[i] = 0; hold[i] = 0; acc[i] = 0;
    end
  end

  // Monitor: record source handshakes and accepted output beats mid-cycle.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 4; i++) acc[i] = s_valid[i] & srdy[i];
    if (mv && m_ready) begin
      q_data.push_back(md);
      q_eof.push_back(me);
      q_gid.push_back(int'(gid));
      q_cyc.push_back(cyc);
    end
    if (ovs) begin
      ov_pulses++;
      ov_cyc = cyc;
    end
  end

  // Sources: advance on accepted bytes, then present the next byte.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        frames[i] = 0;
        pos[i]    = 0;
      end else if (acc[i]) begin
        pos[i]++;
        if (pos[i] == len[i]) begin
          pos[i] = 0;
          frames[i]--;
        end
      end
      s_valid[i]       = (frames[i] > 0) && !hold[i];
      s_data[8*i +: 8] = 8'(i*16 + pos[i]);
      s_eof[i]         = (pos[i] == len[i] - 1);
    end
    m_ready = rmode ? ~m_ready : 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clear_log();
    q_data.delete(); q_eof.delete(); q_gid.delete(); q_cyc.delete();
    ov_pulses = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    rmode = 1'b0;
    for (int i = 0; i < 4; i++) hold[i] = 0;
    tick(2);
    clear_log();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++; if (grant_a !== 2'd3) begin errors++; $display("FAIL reset_grant got %0d want 3", grant_a); end
    checks++; if (grant_b !== 2'd3) begin errors++; $display("FAIL reset_grant8 got %0d want 3", grant_b); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_a); end
    checks++; if (ovs_a !== 1'b0) begin errors++; $display("FAIL reset_oversize got %0b want 0", ovs_a); end
    checks++; if (ovcnt_a !== 16'd0) begin errors++; $display("FAIL reset_ovcnt got %0d want 0", ovcnt_a); end
    reset = 1'b0;
    tick(1);
    checks++; if (s_ready_a !== 4'b0) begin errors++; $display("FAIL post_reset_sready got %b want 0000", s_ready_a); end
    checks++; if (m_valid_a !== 1'b0) begin errors++; $display("FAIL post_reset_mvalid got %0b want 0", m_valid_a); end
    checks++; if (m_eof_a !== 1'b0) begin errors++; $display("FAIL post_reset_meof got %0b want 0", m_eof_a); end
    $display("test_reset done");
  endtask

  task automatic test_two_req();
    sel8 = 1'b0;
    apply_reset();
    len[0] = 4; len[2] = 4; frames[0] = 1; frames[2] = 1;
    tick(20);
    checks++; if (q_data.size() != 8) begin errors++; $display("FAIL two_req_count got %0d want 8", q_data.size()); end
    for (int n = 0; n < 8 && n < q_data.size(); n++) begin
      checks++;
      if (q_data[n] !== 8'((n/4)*32 + n%4) || q_eof[n] !== (n%4 == 3) || q_gid[n] != (n/4)*2) begin
        errors++;
        $display("FAIL two_req_beat%0d got data %h eof %0b gid %0d want data %h eof %0b gid %0d",
                 n, q_data[n], q_eof[n], q_gid[n], 8'((n/4)*32 + n%4), (n%4 == 3), (n/4)*2);
      end
    end
    if (q_cyc.size() == 8) begin
      checks++; if (q_cyc[4] != q_cyc[3] + 2) begin errors++; $display("FAIL two_req_gap got %0d want 2", q_cyc[4] - q_cyc[3]); end
    end
    checks++; if (grant_a !== 2'd2 || busy_a !== 1'b0) begin errors++; $display("FAIL two_req_end got grant %0d busy %0b want 2 0", grant_a, busy_a); end
    $display("test_two_req done");
  endtask

  task automatic test_round_robin();
    sel8 = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin len[i] = 3; frames[i] = 2; end
    tick(40);
    checks++; if (q_data.size() != 24) begin errors++; $display("FAIL rr_count got %0d want 24", q_data.size()); end
    for (int n = 0; n < 15 && n < q_data.size(); n++) begin
      checks++;
      if (q_data[n] !== 8'(((n/3)%4)*16 + n%3) || q_eof[n] !== (n%3 == 2) || q_gid[n] != (n/3)%4) begin
        errors++;
        $display("FAIL rr_beat%0d got data %h eof %0b gid %0d want data %h eof %0b gid %0d",
                 n, q_data[n], q_eof[n], q_gid[n], 8'(((n/3)%4)*16 + n%3), (n%3 == 2), (n/3)%4);
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_backpressure();
    sel8 = 1'b0;
    apply_reset();
    rmode = 1'b1;
    len[1] = 10; frames[1] = 1;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (busy_a) begin
        checks++;
        if (s_ready_a !== (m_ready ? 4'b0010 : 4'b0000)) begin
          errors++; $display("FAIL bp_mirror got %b with m_ready %0b", s_ready_a, m_ready);
        end
      end
    end
    rmode = 1'b0;
    checks++; if (q_data.size() != 10) begin errors++; $display("FAIL bp_count got %0d want 10", q_data.size()); end
    for (int n = 0; n < 10 && n < q_data.size(); n++) begin
      checks++;
      if (q_data[n] !== 8'(16 + n) || q_eof[n] !== (n == 9) || q_gid[n] != 1) begin
        errors++;
        $display("FAIL bp_beat%0d got data %h eof %0b gid %0d want data %h eof %0b gid 1",
                 n, q_data[n], q_eof[n], q_gid[n], 8'(16 + n), (n == 9));
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_stall();
    sel8 = 1'b0;
    apply_reset();
    len[2] = 6; frames[2] = 1;
    for (int c = 0; c < 20 && q_data.size() < 2; c++) tick(1);
    checks++; if (q_data.size() != 2) begin errors++; $display("FAIL stall_start got %0d beats want 2", q_data.size()); end
    hold[2] = 1;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      checks++;
      if (m_valid_a !== 1'b0 || busy_a !== 1'b1) begin
        errors++; $display("FAIL stall_hold got mvalid %0b busy %0b want 0 1", m_valid_a, busy_a);
      end
    end
    hold[2] = 0;
    tick(12);
    checks++; if (q_data.size() != 6) begin errors++; $display("FAIL stall_count got %0d want 6", q_data.size()); end
    for (int n = 0; n < 6 && n < q_data.size(); n++) begin
      checks++;
      if (q_data[n] !== 8'(32 + n) || q_eof[n] !== (n == 5) || q_gid[n] != 2) begin
        errors++; $display("FAIL stall_beat%0d got data %h eof %0b gid %0d", n, q_data[n], q_eof[n], q_gid[n]);
      end
    end
    $display("test_stall done");
  endtask

  task automatic test_oversize();
    sel8 = 1'b1;
    apply_reset();
    len[3] = 12; frames[3] = 1;
    tick(30);
    checks++; if (q_data.size() != 8) begin errors++; $display("FAIL ovs_count got %0d want 8", q_data.size()); end
    for (int n = 0; n < 8 && n < q_data.size(); n++) begin
      checks++;
      if (q_data[n] !== 8'(48 + n) || q_eof[n] !== (n == 7) || q_gid[n] != 3) begin
        errors++; $display("FAIL ovs_beat%0d got data %h eof %0b gid %0d", n, q_data[n], q_eof[n], q_gid[n]);
      end
    end
    checks++; if (ov_pulses != 1) begin errors++; $display("FAIL ovs_pulses got %0d want 1", ov_pulses); end
    if (q_cyc.size() == 8) begin
      checks++; if (ov_cyc != q_cyc[7] + 1) begin errors++; $display("FAIL ovs_pulse_time got %0d want %0d", ov_cyc, q_cyc[7] + 1); end
    end
    checks++; if (ovcnt_b !== 16'd1) begin errors++; $display("FAIL ovs_cnt got %0d want 1", ovcnt_b); end
    checks++; if (frames[3] != 0 || busy_b !== 1'b0) begin errors++; $display("FAIL ovs_drain got frames %0d busy %0b want 0 0", frames[3], busy_b); end
    $display("test_oversize done");
  endtask

  task automatic test_exact();
    sel8 = 1'b1;
    clear_log();
    len[0] = 8; frames[0] = 1;
    tick(20);
    checks++; if (q_data.size() != 8) begin errors++; $display("FAIL exact_count got %0d want 8", q_data.size()); end
    for (int n = 0; n < 8 && n < q_data.size(); n++) begin
      checks++;
      if (q_data[n] !== 8'(n) || q_eof[n] !== (n == 7) || q_gid[n] != 0) begin
        errors++; $display("FAIL exact_beat%0d got data %h eof %0b gid %0d", n, q_data[n], q_eof[n], q_gid[n]);
      end
    end
    checks++; if (ov_pulses != 0) begin errors++; $display("FAIL exact_pulses got %0d want 0", ov_pulses); end
    checks++; if (ovcnt_b !== 16'd1) begin errors++; $display("FAIL exact_cnt got %0d want 1", ovcnt_b); end
    $display("test_exact done");
  endtask

  task automatic test_reset_midframe();
    int eofs;
    sel8 = 1'b0;
    apply_reset();
    len[1] = 10; frames[1] = 1;
    for (int c = 0; c < 20 && q_data.size() < 4; c++) tick(1);
    checks++; if (q_data.size() != 4) begin errors++; $display("FAIL mid_start got %0d beats want 4", q_data.size()); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (m_valid_a !== 1'b0 || s_ready_a !== 4'b0 || m_eof_a !== 1'b0) begin
      errors++; $display("FAIL mid_during got mvalid %0b sready %b meof %0b want 0 0000 0", m_valid_a, s_ready_a, m_eof_a);
    end
    tick(2);
    reset = 1'b0;
    tick(1);
    checks++;
    if (m_valid_a !== 1'b0 || s_ready_a !== 4'b0 || m_eof_a !== 1'b0 || grant_a !== 2'd3) begin
      errors++; $display("FAIL mid_after got mvalid %0b sready %b meof %0b grant %0d want 0 0000 0 3",
                         m_valid_a, s_ready_a, m_eof_a, grant_a);
    end
    eofs = 0;
    foreach (q_eof[k]) if (q_eof[k]) eofs++;
    checks++; if (q_data.size() != 4 || eofs != 0) begin errors++; $display("FAIL mid_abandon got %0d beats %0d eofs want 4 0", q_data.size(), eofs); end
    len[0] = 2; len[1] = 2; frames[0] = 1; frames[1] = 1;
    tick(12);
    checks++; if (q_data.size() != 8) begin errors++; $display("FAIL mid_next_count got %0d want 8", q_data.size()); end
    if (q_gid.size() == 8) begin
      checks++; if (q_gid[4] != 0 || q_gid[6] != 1) begin errors++; $display("FAIL mid_next_grant got %0d %0d want 0 1", q_gid[4], q_gid[6]); end
    end
    $display("test_reset_midframe done");
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_round_robin();
    test_backpressure();
    test_stall();
    test_oversize();
    test_exact();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
MAC_TX_ARBITER -- requirements
Module: mac_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of frame requesters (2..8).
REQ-002 SHALL have parameter MAX_BEATS, default 1500, meaning maximum payload bytes per frame (1..2047).
REQ-003 SHALL have port clk  input  1  system clock (125 MHz MAC domain).
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 SHALL have port s_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port s_eof  input  NUM_REQ  per-requester last-byte flag.
REQ-008 SHALL have port s_ready  output  NUM_REQ  per-requester byte accept.
REQ-009 SHALL have port m_ready  input  1  MAC TX payload ready.
REQ-010 SHALL have port m_valid  output  1  byte valid to MAC TX payload interface.
REQ-011 SHALL have port m_data  output  8  byte to MAC.
REQ-012 SHALL have port m_eof  output  1  last byte of frame to MAC.
REQ-013 SHALL have port grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester.
REQ-014 SHALL have port busy  output  1  high in FORWARD or DRAIN.
REQ-015 SHALL have port oversize  output  1  one-cycle pulse on frame truncation.
REQ-016 SHALL have port oversize_cnt  output  16  saturating count of truncated frames.

Function
REQ-017 SHALL implement FSM states IDLE, FORWARD, DRAIN.
REQ-018 Transfer SHALL occur on a beat where valid and ready are both high on the relevant channel.
REQ-019 In IDLE, if any s_valid is high, SHALL select the first requester with s_valid high searching round-robin from grant_id+1 (mod NUM_REQ), register it into grant_id, clear beat counter, go to FORWARD next cycle.
REQ-020 In IDLE, s_ready SHALL be all zeros and m_valid SHALL be 0.
REQ-021 In FORWARD, m_valid/m_data SHALL equal s_valid/s_data of grant_id combinationally; s_ready[grant_id] SHALL equal m_ready; all other s_ready SHALL be 0.
REQ-022 In FORWARD, m_eof SHALL equal s_eof[grant_id], or 1 when forced per REQ-024.
REQ-023 Beat counter (11 bits) SHALL increment per accepted FORWARD beat.
REQ-024 On the accepted beat where beat counter equals MAX_BEATS-1 and s_eof[grant_id]=0, SHALL force m_eof=1, pulse oversize next cycle, increment oversize_cnt (saturate at 16'hFFFF), go to DRAIN.
REQ-025 On an accepted FORWARD beat with s_eof[grant_id]=1 (including at the MAX_BEATS-th beat), SHALL return to IDLE with no oversize.
REQ-026 In DRAIN, s_ready[grant_id] SHALL be 1, m_valid SHALL be 0; bytes SHALL be discarded; on an accepted beat with s_eof[grant_id]=1, SHALL return to IDLE.
REQ-027 Frames SHALL be atomic: grant SHALL not change between grant and return to IDLE, regardless of other s_valid.
REQ-028 At least one IDLE cycle SHALL separate consecutive frames; minimum frame-to-frame overhead is one cycle.
REQ-029 Grant latency: s_valid high in IDLE -> first byte presentable on m_* the following cycle.
REQ-030 s_valid deassertion mid-frame SHALL stall (m_valid=0) without leaving FORWARD.

Reset
REQ-031 On reset: state IDLE, grant_id = NUM_REQ-1 (requester 0 wins first), beat counter 0, oversize 0, oversize_cnt 0.
REQ-032 During and on the cycle after reset, s_ready, m_valid, m_eof SHALL be 0; reset mid-frame SHALL abandon the frame with no m_eof.

Verification
REQ-033 Requesters 0 and 2 valid simultaneously after reset, 4-byte frames -> req 0 frame forwarded first, one IDLE cycle, then req 2; grant_id 0 then 2.
REQ-034 All four requesters continuously valid, 3-byte frames -> grant order 0,1,2,3,0; each frame exactly 3 m_* beats, m_eof on 3rd.
REQ-035 m_ready toggled 1/0 each cycle during 10-byte frame -> bytes on m_data match source order, no loss/duplication, s_ready[grant] mirrors m_ready.
REQ-036 MAX_BEATS=8, requester sends 12-byte frame -> 8 bytes forwarded, m_eof on 8th, oversize pulse, oversize_cnt=1, remaining 4 bytes absorbed with m_valid=0, then IDLE.
REQ-037 MAX_BEATS=8, exact 8-byte frame -> m_eof on 8th from source, oversize stays 0, oversize_cnt unchanged.
REQ-038 Reset asserted at byte 5 of a 10-byte frame -> outputs per REQ-032; next grant goes to requester 0 if valid.
